uart_word_receiver: RTL and testbench
=====================================

// Module: uart_word_receiver
// PURPOSE
//  Receive end of the 17-bit tagged-word UART link: deserialises bytes off rx_wire_in, validates tags,
//  reassembles one 17-bit word per 3-byte frame. Sits at the FPGA input pad, feeds the downstream consumer.
//  Frame order: B1={2'b00,d[5:0]}, B2={2'b01,d[11:6]}, B3={3'b100,d[16:12]}. Tags allow resync mid-stream.
// PARAMETERS
//  INPUT_CLOCK_FREQ  200_000_000  clk_in frequency, Hz
//  BAUD_RATE         115200       line rate, bits/s; BAUD_COUNT = INPUT_CLOCK_FREQ/BAUD_RATE (integer divide)
//  TIMEOUT_BYTES     4            max idle gap, in byte times (10*BAUD_COUNT cycles), allowed inside a frame
// PORTS
//  clk_in       in   1   system clock
//  rst_n_in     in   1   asynchronous, active-low reset
//  rx_wire_in   in   1   serial line, idle high, 8N1, LSB first; asynchronous to clk_in
//  data_out     out  17  last reassembled word; held until next valid word
//  valid_out    out  1   one-cycle pulse, data_out valid that cycle
//  busy_out     out  1   high while a frame is partially received (after B1, before B3/abort)
//  error_out    out  1   one-cycle pulse on any dropped frame or bad byte
// BEHAVIOUR
//  Reset (rst_n_in=0, async assert, sync release): data_out=0, valid_out=0, busy_out=0, error_out=0,
//   deframer in WAIT_B1, byte rx in IDLE, synchroniser flops preset to 1 (idle line). Mid-byte/mid-frame data discarded.
//  Byte rx: rx_wire_in through 2-FF synchroniser. IDLE -> START on falling edge; sample at BAUD_COUNT/2;
//   if 0 -> DATA, else false start -> IDLE. DATA: 8 samples every BAUD_COUNT cycles, LSB first. STOP: sample
//   after BAUD_COUNT; 1 -> byte_valid pulse next cycle; 0 -> framing error (error_out pulse), byte discarded.
//   Returns to IDLE right after stop sample (no wait for full stop bit) so back-to-back bytes are caught.
//  Tag decode: [7:6]=00 -> B1; [7:6]=01 -> B2; [7:5]=100 -> B3; [7:5]=101 or [7:6]=11 -> BAD.
//  Deframer FSM (advances only on byte_valid):
//   WAIT_B1: B1 -> latch d[5:0], busy_out=1, -> WAIT_B2. B2/B3/BAD -> error_out pulse, stay.
//   WAIT_B2: B2 -> latch d[11:6], -> WAIT_B3. B1 -> error pulse, relatch d[5:0], stay (resync).
//            B3/BAD -> error pulse, busy_out=0, -> WAIT_B1.
//   WAIT_B3: B3 -> data_out={byte[4:0],d[11:6],d[5:0]}, valid_out pulse, busy_out=0, -> WAIT_B1.
//            B1 -> error pulse, relatch d[5:0], -> WAIT_B2. B2/BAD -> error pulse, busy_out=0, -> WAIT_B1.
//  Latency: valid_out rises exactly 1 cycle after byte_valid of B3; data_out updates same edge.
//  Timeout: gap counter clears on each byte_valid, counts while state != WAIT_B1; at TIMEOUT_BYTES*10*BAUD_COUNT
//   -> error pulse, busy_out=0, -> WAIT_B1. Counter saturates; no counting in WAIT_B1.
//  Simultaneous framing error and timeout in same cycle: single error_out pulse, -> WAIT_B1.
//  valid_out and error_out never high in the same cycle. No backpressure: consumer must accept each pulse.
// STRUCTURE
//  Package uart_pkg: tag constants (TAG_B1=2'b00, TAG_B2=2'b01, TAG_B3=3'b100), byte_tag_t enum
//   {B1,B2,B3,BAD}, deframer state enum {WAIT_B1,WAIT_B2,WAIT_B3}, byte-rx state enum.
//  Sub-module uart_byte_rx (sync, oversample, 8N1 byte FSM; outputs byte, byte_valid, frame_err).
//  Top holds tag decode, deframer FSM, timeout counter. Same async active-low reset in both.
// TESTING (sim with INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit, TIMEOUT_BYTES=2)
//  Bytes 0x0D,0x6F,0x9A back-to-back -> one valid_out, data_out=17'h1ABCD, error_out never, busy_out low after.
//  0x3F,0x7F,0x9F then 0x00,0x40,0x80 -> data_out=17'h1FFFF then 17'h00000, two valid_out pulses.
//  0x0D,0x0D,0x6F,0x9A -> one error_out at 2nd byte, then valid_out with data_out=17'h1ABCD (resync).
//  0x0D, 250-clk idle, 0x6F,0x9A -> error_out at timeout (200 clk), no valid_out; next frame recovers.
//  Byte with stop bit forced 0, then glitch <5 clk on idle line -> one error_out, false start ignored.
//  rst_n_in low for 3 clk after 0x0D,0x6F -> all outputs 0 immediately; next 0x9A -> error_out, no valid_out.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Tag constants, state types and tag decoder for the
//                tagged-word UART receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] TAG_B1 = 2'b00;
    localparam logic [1:0] TAG_B2 = 2'b01;
    localparam logic [2:0] TAG_B3 = 3'b100;

    typedef enum logic [1:0] {B1, B2, B3, BAD} byte_tag_t;

    typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3} frame_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic byte_tag_t decode_tag(input logic [7:0] b);
        if (b[7:6] == TAG_B1)      return B1;
        else if (b[7:6] == TAG_B2) return B2;
        else if (b[7:5] == TAG_B3) return B3;
        else                       return BAD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_rx
//  Description : 8N1 byte receiver with 2-FF input synchroniser and
//                mid-bit sampling.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int BAUD_COUNT = 1736
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CW = $clog2(BAUD_COUNT + 1);
    localparam logic [CW-1:0] c_half_last = CW'(BAUD_COUNT / 2 - 1);
    localparam logic [CW-1:0] c_bit_last  = CW'(BAUD_COUNT - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic          r_frame_err;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    // True falling edge only: a line still low after a bad stop bit is not a start
                    if (r_prev && !r_sync2) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) r_byte_valid <= 1'b1;
                        else         r_frame_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/uart_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_receiver
//  Description : Reassembles 17-bit words from tagged 3-byte UART frames,
//                with tag-based resync and inter-byte timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_receiver
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 200_000_000,
    parameter int BAUD_RATE        = 115200,
    parameter int TIMEOUT_BYTES    = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rx_wire_in,
    output logic [16:0] data_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        error_out
);

    localparam int BAUD_COUNT  = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int GAP_LIMIT   = TIMEOUT_BYTES * 10 * BAUD_COUNT;
    localparam int GW          = $clog2(GAP_LIMIT + 1);
    localparam logic [GW-1:0] c_gap_max = GW'(GAP_LIMIT);

    logic [7:0]    w_byte;
    logic          w_byte_valid;
    logic          w_frame_err;
    byte_tag_t     w_tag;
    logic          w_timeout;

    frame_state_t  r_state;
    logic [GW-1:0] r_gap;
    logic [5:0]    r_d_lo;
    logic [5:0]    r_d_mid;
    logic [16:0]   r_data;
    logic          r_valid;
    logic          r_busy;
    logic          r_error;

    uart_byte_rx #(
        .BAUD_COUNT (BAUD_COUNT)
    ) u_byte_rx (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .i_rx         (rx_wire_in),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_tag     = decode_tag(w_byte);
    assign w_timeout = (r_state != WAIT_B1) && (r_gap == c_gap_max);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_gap <= '0;
        end else if (w_byte_valid || r_state == WAIT_B1) begin
            r_gap <= '0;
        end else if (r_gap != c_gap_max) begin
            r_gap <= r_gap + GW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= WAIT_B1;
            r_d_lo  <= '0;
            r_d_mid <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (w_byte_valid) begin
                case (r_state)
                    WAIT_B1: begin
                        if (w_tag == B1) begin
                            r_d_lo  <= w_byte[5:0];
                            r_busy  <= 1'b1;
                            r_state <= WAIT_B2;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    WAIT_B2: begin
                        if (w_tag == B2) begin
                            r_d_mid <= w_byte[5:0];
                            r_state <= WAIT_B3;
                        end else if (w_tag == B1) begin
                            r_error <= 1'b1;
                            r_d_lo  <= w_byte[5:0];
                        end else begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= WAIT_B1;
                        end
                    end
                    WAIT_B3: begin
                        if (w_tag == B3) begin
                            r_data  <= {w_byte[4:0], r_d_mid, r_d_lo};
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= WAIT_B1;
                        end else if (w_tag == B1) begin
                            // A fresh B1 restarts the frame instead of being dropped
                            r_error <= 1'b1;
                            r_d_lo  <= w_byte[5:0];
                            r_state <= WAIT_B2;
                        end else begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= WAIT_B1;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= WAIT_B1;
                    end
                endcase
            end else if (w_timeout || w_frame_err) begin
                r_error <= 1'b1;
                if (w_timeout) begin
                    r_busy  <= 1'b0;
                    r_state <= WAIT_B1;
                end
            end
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign busy_out  = r_busy;
    assign error_out = r_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_receiver
//  Description : Directed, table-driven bench for uart_word_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_receiver;

    localparam int BITCLK = 10;

    logic        clk_in;
    logic        rst_n_in;
    logic        rx_wire_in;
    logic [16:0] data_out;
    logic        valid_out;
    logic        busy_out;
    logic        error_out;

    int n_checks   = 0;
    int n_failures = 0;
    int n_valid    = 0;
    int n_error    = 0;
    int n_overlap  = 0;

    typedef struct {
        int             n;
        logic [4:0][7:0] b;
        int             exp_valid;
        int             exp_err;
        logic [16:0]    exp_data;
        logic           exp_busy;
    } vec_t;

    vec_t vecs [11];

    uart_word_receiver #(
        .INPUT_CLOCK_FREQ (1_000_000),
        .BAUD_RATE        (100_000),
        .TIMEOUT_BYTES    (2)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rx_wire_in (rx_wire_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .busy_out   (busy_out),
        .error_out  (error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (valid_out) n_valid = n_valid + 1;
            if (error_out) n_error = n_error + 1;
            if (valid_out && error_out) n_overlap = n_overlap + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_failures = n_failures + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_wire_in = b;
        repeat (BITCLK) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx_wire_in = 1'b1;
    endtask

    task automatic idle(input int cycles);
        rx_wire_in = 1'b1;
        repeat (cycles) @(negedge clk_in);
    endtask

    int v0;
    int e0;

    initial begin
        vecs[0]  = '{3, {8'h00, 8'h00, 8'h9A, 8'h6F, 8'h0D}, 1, 0, 17'h1ABCD, 1'b0};
        vecs[1]  = '{3, {8'h00, 8'h00, 8'h9F, 8'h7F, 8'h3F}, 1, 0, 17'h1FFFF, 1'b0};
        vecs[2]  = '{3, {8'h00, 8'h00, 8'h80, 8'h40, 8'h00}, 1, 0, 17'h00000, 1'b0};
        vecs[3]  = '{4, {8'h00, 8'h9A, 8'h6F, 8'h0D, 8'h0D}, 1, 1, 17'h1ABCD, 1'b0};
        vecs[4]  = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h6F}, 0, 1, 17'h1ABCD, 1'b0};
        vecs[5]  = '{3, {8'h00, 8'h00, 8'hC0, 8'h6F, 8'h0D}, 0, 1, 17'h1ABCD, 1'b0};
        vecs[6]  = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}, 0, 0, 17'h1ABCD, 1'b1};
        vecs[7]  = '{2, {8'h00, 8'h00, 8'h00, 8'h9F, 8'h7F}, 1, 0, 17'h1FFFF, 1'b0};
        vecs[8]  = '{5, {8'h9A, 8'h6F, 8'h0D, 8'h6F, 8'h0D}, 1, 1, 17'h1ABCD, 1'b0};
        vecs[9]  = '{2, {8'h00, 8'h00, 8'h00, 8'hA0, 8'h0D}, 0, 1, 17'h1ABCD, 1'b0};
        vecs[10] = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h9A}, 0, 1, 17'h1ABCD, 1'b0};

        rx_wire_in = 1'b1;
        rst_n_in   = 1'b0;
        #12;
        check("reset_data",  32'(data_out),  32'h0);
        check("reset_valid", 32'(valid_out), 32'h0);
        check("reset_busy",  32'(busy_out),  32'h0);
        check("reset_error", 32'(error_out), 32'h0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(20);

        for (int k = 0; k < 11; k++) begin
            v0 = n_valid;
            e0 = n_error;
            for (int j = 0; j < vecs[k].n; j++) send_byte(vecs[k].b[j], 1'b1);
            idle(20);
            check($sformatf("vec%0d_valid", k), 32'(n_valid - v0), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_error", k), 32'(n_error - e0), 32'(vecs[k].exp_err));
            check($sformatf("vec%0d_data",  k), 32'(data_out),     32'(vecs[k].exp_data));
            check($sformatf("vec%0d_busy",  k), 32'(busy_out),     32'(vecs[k].exp_busy));
        end

        // Inter-byte timeout inside a frame
        v0 = n_valid;
        e0 = n_error;
        send_byte(8'h0D, 1'b1);
        idle(150);
        check("tmo_early_error", 32'(n_error - e0), 32'h0);
        check("tmo_early_busy",  32'(busy_out),     32'h1);
        idle(100);
        check("tmo_error", 32'(n_error - e0), 32'h1);
        check("tmo_busy",  32'(busy_out),     32'h0);
        send_byte(8'h6F, 1'b1);
        send_byte(8'h9A, 1'b1);
        idle(20);
        check("tmo_tail_error", 32'(n_error - e0), 32'h3);
        check("tmo_tail_valid", 32'(n_valid - v0), 32'h0);
        send_byte(8'h0D, 1'b1);
        send_byte(8'h6F, 1'b1);
        send_byte(8'h9A, 1'b1);
        idle(20);
        check("tmo_recover_valid", 32'(n_valid - v0), 32'h1);
        check("tmo_recover_data",  32'(data_out),     32'h1ABCD);

        // Framing error followed by a short glitch on the idle line
        v0 = n_valid;
        e0 = n_error;
        send_byte(8'h55, 1'b0);
        idle(30);
        rx_wire_in = 1'b0;
        repeat (3) @(negedge clk_in);
        idle(40);
        check("ferr_error", 32'(n_error - e0), 32'h1);
        check("ferr_valid", 32'(n_valid - v0), 32'h0);
        send_byte(8'h3F, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_byte(8'h9F, 1'b1);
        idle(20);
        check("ferr_after_valid", 32'(n_valid - v0), 32'h1);
        check("ferr_after_error", 32'(n_error - e0), 32'h1);
        check("ferr_after_data",  32'(data_out),     32'h1FFFF);

        // Asynchronous reset in the middle of a frame
        send_byte(8'h0D, 1'b1);
        send_byte(8'h6F, 1'b1);
        idle(20);
        check("rst_pre_busy", 32'(busy_out), 32'h1);
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_async_data", 32'(data_out), 32'h0);
        check("rst_async_busy", 32'(busy_out), 32'h0);
        repeat (3) @(negedge clk_in);
        check("rst_hold_valid", 32'(valid_out), 32'h0);
        check("rst_hold_error", 32'(error_out), 32'h0);
        rst_n_in = 1'b1;
        idle(20);
        v0 = n_valid;
        e0 = n_error;
        send_byte(8'h9A, 1'b1);
        idle(20);
        check("rst_post_error", 32'(n_error - e0), 32'h1);
        check("rst_post_valid", 32'(n_valid - v0), 32'h0);
        check("rst_post_data",  32'(data_out),     32'h0);

        check("valid_error_overlap", 32'(n_overlap), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
